// File: rtl/regfile_dump.sv
// regfile_dump: snapshots register file entries and streams 5-byte records.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum byte per dump.
module regfile_dump #(
    parameter int FIRST = 0,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  raddr,
    input  logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

    localparam logic [4:0] FIRST_A = 5'(FIRST);
    localparam logic [4:0] LAST_A  = 5'(FIRST + NREGS - 1);

    state_t      state_q, state_d;
    logic [4:0]  raddr_q, raddr_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        xfer;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [2:0] CSUM_CNT = 3'd5;
    logic [7:0]  csum_q, csum_d;
`endif

    assign xfer = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    raddr_d = FIRST_A;
                    cnt_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                // x0 reads as zero no matter what the port returns
                shift_d = (raddr_q == 5'd0) ? 32'h0 : rdata;
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    cnt_d = cnt_q + 3'd1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data;
`endif
                    if (cnt_q >= 3'd1 && cnt_q <= 3'd3) begin
                        shift_d = {shift_q[23:0], 8'h00};
                    end
                    if (cnt_q == 3'd4) begin
                        if (raddr_q == LAST_A) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            cnt_d   = CSUM_CNT;
`else
                            state_d = FIN;
`endif
                        end else begin
                            state_d = LOAD;
                            raddr_d = raddr_q + 5'd1;
                        end
                    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    if (cnt_q == CSUM_CNT) begin
                        state_d = FIN;
                    end
`endif
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        raddr    = raddr_q;
        case (state_q)
            LOAD: busy = 1'b1;
            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (cnt_q == 3'd0) begin
                    tx_data = {3'b000, raddr_q};
`ifdef REGFILE_DUMP_CHECKSUM_EN
                end else if (cnt_q == CSUM_CNT) begin
                    tx_data = csum_q;
`endif
                end else begin
                    tx_data = shift_q[31:24];
                end
            end
            FIN: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: full dumps, stalls, abort, snapshot rule.
// Expected byte streams come from a register-array model.
module tb_regfile_dump;
    logic        clk = 1'b0;
    logic        rst, start, start2, tx_ready;
    logic        busy, done, tx_valid;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        busy2, done2, tx_valid2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [7:0]  tx_data2;

    logic [31:0] regs [32];
    logic [31:0] snap [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got [$];
    int n_chk = 0;
    int n_fail = 0;
    int done_cnt, busy_cnt, last_c, done_c, seen;
    bit fin, aborted;

    always #5 clk = ~clk;

    assign rdata  = regs[raddr];
    assign rdata2 = regs[raddr2];

    regfile_dump dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    regfile_dump #(.FIRST(10), .NREGS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .busy(busy2), .done(done2), .raddr(raddr2), .rdata(rdata2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference stream: each record is index then value MSB first.
    function automatic void build(input int first, input int n);
        logic [31:0] v;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        logic [7:0] x;
`endif
        exp_q.delete();
        for (int r = first; r < first + n; r++) begin
            v = (r == 0) ? 32'h0 : snap[r];
            exp_q.push_back(8'(r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endfunction

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
    endtask

    task automatic take_snap();
        for (int i = 0; i < 32; i++) snap[i] = regs[i];
    endtask

    // Drives and samples at negedges; a handshake is decided before the edge.
    task automatic run(input bit rnd, input int mid_start,
                       input int wr_byte, input int abort_byte);
        bit stalled;
        logic [7:0] held;
        got.delete();
        done_cnt = 0; busy_cnt = 0; fin = 0; aborted = 0;
        last_c = -1; done_c = -1; stalled = 0; held = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4000 && !fin && !aborted; c++) begin
            if (stalled) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(held));
            end
            if (done) begin
                done_cnt++;
                done_c = c;
                fin = 1;
            end else begin
                if (busy) busy_cnt++;
                start = (got.size() == mid_start);
                if (got.size() == wr_byte) begin
                    regs[2] = 32'hA5A5A5A5;
                    regs[3] = 32'h00000007;
                end
                if (abort_byte >= 0 && got.size() == abort_byte && tx_valid) begin
                    rst = 1'b1;
                    tx_ready = 1'b0;
                    aborted = 1;
                end else begin
                    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    stalled = tx_valid && !tx_ready;
                    held = tx_data;
                    if (tx_valid && tx_ready) begin
                        got.push_back(tx_data);
                        last_c = c;
                    end
                    @(negedge clk);
                end
            end
        end
        start = 1'b0;
        if (!aborted) chk("frame_done_seen", 32'(fin), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hFFFFFFFF;
        regs[5] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        take_snap();
        build(0, 32);
        run(0, -1, -1, -1);
        cmp_seq("full");
        chk("rec5_idx", 32'(got[25]), 32'h05);
        chk("rec5_b1", 32'(got[26]), 32'hDE);
        chk("rec5_b2", 32'(got[27]), 32'hAD);
        chk("rec5_b3", 32'(got[28]), 32'hBE);
        chk("rec5_b4", 32'(got[29]), 32'hEF);
        for (int i = 0; i < 5; i++) chk("rec0_zero", 32'(got[i]), 32'h00);
        chk("done_count", 32'(done_cnt), 32'd1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk("busy_cycles", 32'(busy_cnt), 32'd193);
`else
        chk("busy_cycles", 32'(busy_cnt), 32'd192);
`endif
        chk("done_latency", 32'(done_c - last_c), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);

        run(1, -1, -1, -1);
        cmp_seq("rnd");
        chk("rnd_done_count", 32'(done_cnt), 32'd1);
        @(negedge clk);

        run(0, 20, -1, 38);
        chk("abort_hit", 32'(aborted), 32'd1);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_raddr", 32'(raddr), 32'd0);
        chk("abort_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        run(0, -1, -1, -1);
        cmp_seq("restart");
        chk("restart_first", 32'(got[0]), 32'h00);
        @(negedge clk);

        take_snap();
        snap[3] = 32'h00000007;
        build(0, 32);
        run(0, -1, 11, -1);
        cmp_seq("snap");
        @(negedge clk);

        regs[10] = 32'd1;
        regs[11] = 32'd2;
        take_snap();
        build(10, 2);
        got.delete();
        fin = 0;
        tx_ready = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (done2) fin = 1;
            else begin
                if (tx_valid2) got.push_back(tx_data2);
                @(negedge clk);
            end
        end
        chk("dut2_done", 32'(fin), 32'd1);
        cmp_seq("first10");
        chk("first10_idx", 32'(got[0]), 32'h0A);
        chk("first10_idx2", 32'(got[5]), 32'h0B);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
